// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 definitions for the iterative cipher core.
//   SBOX / sbox()   forward S-box table and lookup
//   RCON            round constants indexed by round 1..10 (other slots zero)
//   xtime()         multiply by x in GF(2^8)
//   mix_column()    MixColumns on one 32-bit column (row 0 in the MSB)
//   shift_rows()    ShiftRows on a 128-bit state, byte 0 in [127:120]
//   fsm_t           controller states
package aes_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // 16 entries so a 4-bit round index never falls outside the table.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // State is column-major: byte (r + 4*c) is row r of column c.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_round_comb.sv
// aes_round_comb: one AES-128 encryption round, purely combinational.
//   st, rk     state and round key entering this round
//   rnd        round number 1..10 (selects Rcon)
//   last       round 10: MixColumns is skipped
//   st_next    state after AddRoundKey with the new round key
//   rk_next    round key for this round
module aes_round_comb
    import aes_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] rk,
    input  logic [3:0]   rnd,
    input  logic         last,
    output logic [127:0] st_next,
    output logic [127:0] rk_next
);

    logic [31:0]  w0, w1, w2, w3, t, nw0, nw1, nw2, nw3;
    logic [127:0] sb, sr, mc;

    always_comb begin
        {w0, w1, w2, w3} = rk;
        // RotWord then SubWord of the last word, Rcon into the top byte.
        t   = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
              ^ {RCON[rnd], 24'h000000};
        nw0 = w0 ^ t;
        nw1 = w1 ^ nw0;
        nw2 = w2 ^ nw1;
        nw3 = w3 ^ nw2;
        rk_next = {nw0, nw1, nw2, nw3};

        sb = '0;
        for (int i = 0; i < 16; i++) begin
            sb[127 - 8*i -: 8] = sbox(st[127 - 8*i -: 8]);
        end
        sr = shift_rows(sb);
        mc = '0;
        for (int c = 0; c < 4; c++) begin
            mc[127 - 32*c -: 32] = last ? sr[127 - 32*c -: 32] : mix_column(sr[127 - 32*c -: 32]);
        end
        st_next = mc ^ rk_next;
    end

endmodule

// File: rtl/aes_128_iter.sv
// aes_128_iter: iterative AES-128 encryption core, UNROLL rounds per clock.
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     plaintext + key handshake (state, key)
//   out_valid/out_ready   ciphertext handshake (out held while stalled)
//   busy                  rounds in progress
//   block_cnt             wrapping count of delivered ciphertext blocks
//
//   state | meaning
//   IDLE  | waiting for a block
//   RUN   | computing rounds, UNROLL per clock
//   DONE  | ciphertext valid, waiting for out_ready
module aes_128_iter
    import aes_pkg::*;
#(
    parameter int UNROLL = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     state,
    input  logic [127:0]     key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out,
    output logic             busy,
    output logic [CNT_W-1:0] block_cnt
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
        $error("aes_128_iter: UNROLL must be 1, 2, 5 or 10");
    end

    fsm_t         fsm;
    logic [127:0] st_q, rk_q, st_fin, rk_fin;
    logic [3:0]   rnd_q;
    logic         accept;

    assign in_ready = (fsm == IDLE) || (fsm == DONE && out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (fsm == RUN);

    for (genvar i = 0; i < UNROLL; i++) begin : g_rnd
        logic [127:0] st_i, rk_i, st_o, rk_o;
        logic [3:0]   rnd_i;
        if (i == 0) begin : g_first
            assign st_i = st_q;
            assign rk_i = rk_q;
        end else begin : g_chain
            assign st_i = g_rnd[i-1].st_o;
            assign rk_i = g_rnd[i-1].rk_o;
        end
        assign rnd_i = rnd_q + 4'(i);
        aes_round_comb u_round (
            .st      (st_i),
            .rk      (rk_i),
            .rnd     (rnd_i),
            .last    (rnd_i == 4'd10),
            .st_next (st_o),
            .rk_next (rk_o)
        );
    end

    assign st_fin = g_rnd[UNROLL-1].st_o;
    assign rk_fin = g_rnd[UNROLL-1].rk_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            st_q      <= '0;
            rk_q      <= '0;
            rnd_q     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            block_cnt <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (accept) begin
                        st_q  <= state ^ key;
                        rk_q  <= key;
                        rnd_q <= 4'd1;
                        fsm   <= RUN;
                    end
                end
                RUN: begin
                    st_q  <= st_fin;
                    rk_q  <= rk_fin;
                    rnd_q <= rnd_q + 4'(UNROLL);
                    // This step's rounds end at round 10.
                    if (rnd_q == 4'(11 - UNROLL)) begin
                        out       <= st_fin;
                        out_valid <= 1'b1;
                        fsm       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        block_cnt <= block_cnt + CNT_W'(1);
                        out_valid <= 1'b0;
                        if (accept) begin
                            st_q  <= state ^ key;
                            rk_q  <= key;
                            rnd_q <= 4'd1;
                            fsm   <= RUN;
                        end else begin
                            fsm <= IDLE;
                        end
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_128_iter.sv
// tb_aes_128_iter: directed + random checks of aes_128_iter at UNROLL 1/2/5/10
// and with a 2-bit block counter, against a byte-level AES reference model
// whose S-box is derived from GF(2^8) inversion and the affine map.
module tb_aes_128_iter;

    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Z_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [4:0]       in_valid_s, out_ready_s, in_ready_w, out_valid_w, busy_w;
    logic [4:0][127:0] state_s, key_s, out_w;
    logic [3:0][15:0] cnt_w;
    logic [1:0]       cnt4;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  sb_tab [256];
    logic [15:0] exp_cnt [5];
    int          nn [4] = '{10, 5, 2, 1};

    aes_128_iter #(.UNROLL(1), .CNT_W(16)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[0]), .in_ready(in_ready_w[0]),
        .state(state_s[0]), .key(key_s[0]), .out_valid(out_valid_w[0]),
        .out_ready(out_ready_s[0]), .out(out_w[0]), .busy(busy_w[0]), .block_cnt(cnt_w[0]));
    aes_128_iter #(.UNROLL(2), .CNT_W(16)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[1]), .in_ready(in_ready_w[1]),
        .state(state_s[1]), .key(key_s[1]), .out_valid(out_valid_w[1]),
        .out_ready(out_ready_s[1]), .out(out_w[1]), .busy(busy_w[1]), .block_cnt(cnt_w[1]));
    aes_128_iter #(.UNROLL(5), .CNT_W(16)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[2]), .in_ready(in_ready_w[2]),
        .state(state_s[2]), .key(key_s[2]), .out_valid(out_valid_w[2]),
        .out_ready(out_ready_s[2]), .out(out_w[2]), .busy(busy_w[2]), .block_cnt(cnt_w[2]));
    aes_128_iter #(.UNROLL(10), .CNT_W(16)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[3]), .in_ready(in_ready_w[3]),
        .state(state_s[3]), .key(key_s[3]), .out_valid(out_valid_w[3]),
        .out_ready(out_ready_s[3]), .out(out_w[3]), .busy(busy_w[3]), .block_cnt(cnt_w[3]));
    aes_128_iter #(.UNROLL(1), .CNT_W(2)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid_s[4]), .in_ready(in_ready_w[4]),
        .state(state_s[4]), .key(key_s[4]), .out_valid(out_valid_w[4]),
        .out_ready(out_ready_s[4]), .out(out_w[4]), .busy(busy_w[4]), .block_cnt(cnt4));

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [31:0]  tmp;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc, t0, t1, t2, t3;
        logic [127:0] r;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb_tab[tmp[31:24]], sb_tab[tmp[23:16]], sb_tab[tmp[15:8]], sb_tab[tmp[7:0]]};
                tmp[31:24] = tmp[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) s[i] = sb_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) t[q + 4*c] = s[q + 4*((c + q) % 4)];
            for (int c = 0; c < 4; c++) begin
                t0 = t[4*c]; t1 = t[4*c+1]; t2 = t[4*c+2]; t3 = t[4*c+3];
                if (rd < 10) begin
                    s[4*c]   = gmul(t0, 8'h02) ^ gmul(t1, 8'h03) ^ t2 ^ t3;
                    s[4*c+1] = t0 ^ gmul(t1, 8'h02) ^ gmul(t2, 8'h03) ^ t3;
                    s[4*c+2] = t0 ^ t1 ^ gmul(t2, 8'h02) ^ gmul(t3, 8'h03);
                    s[4*c+3] = gmul(t0, 8'h03) ^ t1 ^ t2 ^ gmul(t3, 8'h02);
                end else begin
                    s[4*c] = t0; s[4*c+1] = t1; s[4*c+2] = t2; s[4*c+3] = t3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rd + i/4][31 - 8*(i%4) -: 8];
        end
        r = '0;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = s[i];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [15:0] get_cnt(input logic [2:0] d);
        return (d == 3'd4) ? {14'b0, cnt4} : cnt_w[d[1:0]];
    endfunction

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input logic [2:0] d, output int lat);
        lat = 0;
        while (!out_valid_w[d] && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic do_block(input logic [2:0] d, input logic [127:0] pt, input logic [127:0] k,
                            output int lat, output logic [127:0] ct);
        int n;
        state_s[d] = pt;
        key_s[d] = k;
        in_valid_s[d] = 1'b1;
        #1;
        n = 0;
        while (!in_ready_w[d] && n < 50) begin
            step();
            n++;
        end
        step();
        in_valid_s[d] = 1'b0;
        wait_done(d, lat);
        ct = out_w[d];
    endtask

    task automatic hand(input logic [2:0] d, input logic [127:0] ct);
        out_ready_s[d] = 1'b1;
        step();
        exp_cnt[d] = exp_cnt[d] + 16'd1;
        chk($sformatf("hand_valid_d%0d", d), {127'b0, out_valid_w[d]}, 128'd0);
        chk($sformatf("hand_out_held_d%0d", d), out_w[d], ct);
        chk($sformatf("hand_cnt_d%0d", d), {112'b0, get_cnt(d)},
            {112'b0, (d == 3'd4) ? (exp_cnt[d] & 16'h3) : exp_cnt[d]});
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int          lat, cyc, last, kq, j;
        logic        acc, hnd;
        logic [2:0]  dd;
        logic [127:0] ct, pt, k, ex;
        logic [127:0] bp [5];
        logic [127:0] bk [5];
        logic [127:0] bexp [5];
        logic [1:0]  wrap_seq [5];

        wrap_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst = 1'b1;
        in_valid_s = '0; out_ready_s = '0; state_s = '0; key_s = '0;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] a, inv;
            a = 8'(x);
            inv = 8'h00;
            if (a != 8'h00) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gmul(inv, a);
            end
            sb_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int d = 0; d < 5; d++) exp_cnt[d] = 16'd0;

        step(); step();
        rst = 1'b0;
        #1;
        for (int d = 0; d < 5; d++) begin
            dd = 3'(d);
            chk($sformatf("rst_valid_d%0d", d), {127'b0, out_valid_w[dd]}, 128'd0);
            chk($sformatf("rst_busy_d%0d", d), {127'b0, busy_w[dd]}, 128'd0);
            chk($sformatf("rst_in_ready_d%0d", d), {127'b0, in_ready_w[dd]}, 128'd1);
            chk($sformatf("rst_out_d%0d", d), out_w[dd], 128'd0);
            chk($sformatf("rst_cnt_d%0d", d), {112'b0, get_cnt(dd)}, 128'd0);
        end

        // FIPS-197 Appendix B, UNROLL=1
        out_ready_s[0] = 1'b1;
        do_block(3'd0, B_PT, B_K, lat, ct);
        chk("appb_latency", 128'(lat), 128'd10);
        chk("appb_out", ct, B_CT);
        hand(3'd0, B_CT);

        // FIPS-197 C.1 for every UNROLL
        for (int d = 0; d < 4; d++) begin
            dd = 3'(d);
            out_ready_s[dd] = 1'b1;
            do_block(dd, C1_PT, C1_K, lat, ct);
            chk($sformatf("c1_latency_d%0d", d), 128'(lat), 128'(nn[d]));
            chk($sformatf("c1_out_d%0d", d), ct, C1_CT);
            hand(dd, C1_CT);
        end

        // Backpressure on UNROLL=2, then same-edge handoff + accept
        out_ready_s[1] = 1'b0;
        do_block(3'd1, 128'd0, 128'd0, lat, ct);
        chk("bp_latency", 128'(lat), 128'd5);
        chk("bp_out", ct, Z_CT);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("bp_hold_out", out_w[1], Z_CT);
            chk("bp_hold_valid", {127'b0, out_valid_w[1]}, 128'd1);
            chk("bp_in_ready", {127'b0, in_ready_w[1]}, 128'd0);
            chk("bp_cnt", {112'b0, get_cnt(3'd1)}, {112'b0, exp_cnt[1]});
        end
        state_s[1] = C1_PT; key_s[1] = C1_K; in_valid_s[1] = 1'b1; out_ready_s[1] = 1'b1;
        #1;
        chk("bp_release_in_ready", {127'b0, in_ready_w[1]}, 128'd1);
        step();
        in_valid_s[1] = 1'b0;
        exp_cnt[1] = exp_cnt[1] + 16'd1;
        chk("bp_release_valid", {127'b0, out_valid_w[1]}, 128'd0);
        chk("bp_release_busy", {127'b0, busy_w[1]}, 128'd1);
        chk("bp_release_cnt", {112'b0, get_cnt(3'd1)}, {112'b0, exp_cnt[1]});
        wait_done(3'd1, lat);
        chk("bp_next_latency", 128'(lat), 128'd5);
        chk("bp_next_out", out_w[1], C1_CT);
        hand(3'd1, C1_CT);

        // Random single blocks against the model
        for (int d = 0; d < 4; d++) begin
            dd = 3'(d);
            for (int i = 0; i < 3; i++) begin
                pt = rand128();
                k = rand128();
                ex = ref_aes(pt, k);
                do_block(dd, pt, k, lat, ct);
                chk($sformatf("rand_latency_d%0d", d), 128'(lat), 128'(nn[d]));
                chk($sformatf("rand_out_d%0d", d), ct, ex);
                hand(dd, ex);
            end
        end

        // Back-to-back streaming on UNROLL=5 (N=2, one result per 3 cycles)
        for (int i = 0; i < 5; i++) begin
            bp[i] = rand128();
            bk[i] = rand128();
            bexp[i] = ref_aes(bp[i], bk[i]);
        end
        out_ready_s[2] = 1'b1;
        state_s[2] = bp[0]; key_s[2] = bk[0]; in_valid_s[2] = 1'b1;
        #1;
        j = 0; kq = 0; cyc = 0; last = 0;
        while (kq < 5 && cyc < 200) begin
            acc = in_valid_s[2] && in_ready_w[2];
            hnd = out_valid_w[2];
            if (hnd) begin
                chk($sformatf("b2b_out_%0d", kq), out_w[2], bexp[kq]);
                if (kq > 0) chk($sformatf("b2b_spacing_%0d", kq), 128'(cyc - last), 128'd3);
                last = cyc;
                kq++;
                exp_cnt[2] = exp_cnt[2] + 16'd1;
            end
            step();
            cyc++;
            if (acc) begin
                j++;
                if (j < 5) begin
                    state_s[2] = bp[j];
                    key_s[2] = bk[j];
                end else begin
                    in_valid_s[2] = 1'b0;
                end
            end
        end
        chk("b2b_count", 128'(kq), 128'd5);
        chk("b2b_cnt", {112'b0, get_cnt(3'd2)}, {112'b0, exp_cnt[2]});
        chk("b2b_idle_valid", {127'b0, out_valid_w[2]}, 128'd0);

        // Reset at the 4th RUN edge, UNROLL=1
        out_ready_s[0] = 1'b0;
        state_s[0] = C1_PT; key_s[0] = C1_K; in_valid_s[0] = 1'b1;
        #1;
        step();
        in_valid_s[0] = 1'b0;
        step(); step(); step();
        chk("mid_busy", {127'b0, busy_w[0]}, 128'd1);
        chk("mid_valid", {127'b0, out_valid_w[0]}, 128'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        for (int d = 0; d < 5; d++) exp_cnt[d] = 16'd0;
        chk("abort_valid", {127'b0, out_valid_w[0]}, 128'd0);
        chk("abort_out", out_w[0], 128'd0);
        chk("abort_busy", {127'b0, busy_w[0]}, 128'd0);
        chk("abort_in_ready", {127'b0, in_ready_w[0]}, 128'd1);
        chk("abort_cnt", {112'b0, get_cnt(3'd0)}, 128'd0);
        out_ready_s[0] = 1'b1;
        do_block(3'd0, C1_PT, C1_K, lat, ct);
        chk("after_abort_latency", 128'(lat), 128'd10);
        chk("after_abort_out", ct, C1_CT);
        hand(3'd0, C1_CT);

        // 2-bit counter wraps: 1,2,3,0,1
        out_ready_s[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pt = rand128();
            k = rand128();
            ex = ref_aes(pt, k);
            do_block(3'd4, pt, k, lat, ct);
            chk("wrap_out", ct, ex);
            hand(3'd4, ex);
            chk($sformatf("wrap_seq_%0d", i), {126'b0, cnt4}, {126'b0, wrap_seq[i]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
